fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Holds the program counter; issues sequential fetch addresses (PC+4) to instruction fetch.
//  Consumes the 64-bit sign-extended branch immediates (imm26 for B, imm19 for CB) from decode.
//  Computes the taken-branch target, redirects the PC and pulses a flush for younger instructions.
//  Sits between decode/branch resolution and the instruction memory port.
// PARAMETERS
//  PC_WIDTH   64         PC / address width; immediates arrive already extended to this width
//  RESET_PC   64'h0      PC value loaded on reset
// PORTS
//  clk            in   1         single clock, rising edge
//  reset_n        in   1         asynchronous, active-low reset
//  stall          in   1         hazard stall; blocks the sequential PC advance only
//  fetch_ready    in   1         imem accepts fetch_pc this cycle
//  fetch_valid    out  1         fetch_pc is valid
//  fetch_pc       out  PC_WIDTH  address to fetch
//  br_valid       in   1         resolved branch presented
//  br_ready       out  1         unit can accept a branch this cycle
//  br_taken       in   1         branch is taken (ignored unless br_valid)
//  br_kind        in   2         br_kind_t: BK_B, BK_CB, BK_BR
//  br_pc          in   PC_WIDTH  PC of the branch instruction
//  br_imm_ext     in   PC_WIDTH  sign-extended word offset (B/CB)
//  br_reg_target  in   PC_WIDTH  register target (BR)
//  redirect_flush out  1         one-cycle pulse: squash younger in-flight instructions
//  misalign_err   out  1         sticky flag: a BR target had bits[1:0] != 0
// BEHAVIOUR
//  Reset (async, any state): state=BOOT, pc_q=RESET_PC, fetch_valid=0, br_ready=0,
//   redirect_flush=0, misalign_err=0.
//  fetch_pc = pc_q at all times; fetch_valid=1 only in RUN.
//  FSM states: BOOT, RUN, REDIR.
//   BOOT: fetch_valid=0, br_ready=0; unconditional -> RUN next cycle.
//   RUN:  br_ready=1. Branch accepted when br_valid && br_ready.
//     - Accepted and taken: pc_q <= target; redirect_flush <= 1 (registered, so high the
//       following cycle); -> REDIR.
//     - Else fetch handshake (fetch_valid && fetch_ready && !stall): pc_q <= pc_q + 4.
//     - Else: pc_q holds.
//   REDIR: fetch_valid=0, br_ready=0, redirect_flush=1 this cycle only; -> RUN. One-cycle bubble.
//  Target arithmetic (mod 2^PC_WIDTH, wrap silently):
//   BK_B, BK_CB: br_pc + {br_imm_ext[PC_WIDTH-3:0], 2'b00}
//   BK_BR:       {br_reg_target[PC_WIDTH-1:2], 2'b00}; if br_reg_target[1:0] != 0, set
//                misalign_err (sticky until reset).
//   Illegal kind 2'b11: treated as not taken; sets misalign_err.
//  Sequential increment: pc_q + 4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
//  Simultaneous events:
//   - Taken branch beats both the fetch handshake and stall; the PC+4 of that cycle is discarded.
//   - Not-taken branch completes its handshake with no PC effect; the sequential advance still
//     applies.
//   - stall=1 with fetch_ready=1: no advance.
//  A branch offered while br_ready=0 stays un-accepted; the upstream holds it stable.
//  Reset asserted mid-REDIR: the pending flush is dropped (redirect_flush=0 immediately).
// STRUCTURE
//  Package fetch_pkg:
//   - typedef enum logic[1:0] {BK_B, BK_CB, BK_BR} br_kind_t
//   - typedef enum {BOOT, RUN, REDIR} pc_state_t
//   - localparam INSTR_BYTES = 4
//  Sub-module branch_target_calc: combinational kind mux + shift-add; produces target and the
//  misalign indication.
//  Top module holds the FSM, pc_q, the flush register and the sticky error flag.
// TESTING
//  1. Reset release, fetch_ready=1 -> one cycle fetch_valid=0, then fetch_pc 0,4,8,12 per cycle.
//  2. pc_q=0x100, fetch_ready=1, stall=1 for 3 cycles -> fetch_pc holds 0x100; advances to 0x104
//     once stall drops.
//  3. B taken, br_pc=0x200, br_imm_ext=-3 (0xFFF..FD) -> next PC 0x1F4; redirect_flush high for
//     exactly 1 cycle; fetch_valid=0 that cycle.
//  4. CB taken, br_imm_ext=5, in the same cycle as a fetch handshake at pc 0x40, br_pc=0x3C
//     -> PC=0x50, not 0x44.
//  5. BR taken, br_reg_target=0x1003 -> PC=0x1000; misalign_err=1 and stays 1 until reset_n low.
//  6. pc_q=64'hFFFF_FFFF_FFFF_FFFC, handshake -> PC=0; reset_n low during REDIR -> PC=RESET_PC
//     and flush=0 asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC unit: branch kinds, FSM states, instruction size.
// Pure declarations; no latency or backpressure of its own.
package fetch_pkg;

    typedef enum logic [1:0] {
        BK_B  = 2'd0,
        BK_CB = 2'd1,
        BK_BR = 2'd2
    } br_kind_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } pc_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target mux and shift-add; flags misaligned register targets and illegal kinds.
// Purely combinational, zero latency, no backpressure.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [1:0]          kind_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] imm_ext_i,
    input  logic [PC_WIDTH-1:0] reg_target_i,
    output logic [PC_WIDTH-1:0] target_o,
    output logic                misalign_o,
    output logic                illegal_o
);

    always_comb begin
        target_o   = pc_i + (imm_ext_i << 2);
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (kind_i)
            BK_B, BK_CB: target_o = pc_i + (imm_ext_i << 2);
            BK_BR: begin
                // Register targets are force-aligned; the dropped bits are reported instead.
                target_o   = reg_target_i & ~PC_WIDTH'(3);
                misalign_o = (reg_target_i[1:0] != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter with sequential fetch, taken-branch redirect, flush pulse and sticky misalign flag.
// Redirect costs one bubble cycle; stall/fetch_ready only gate the PC+4 advance, never a redirect.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                     PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] fetch_pc,
    input  logic                br_valid,
    output logic                br_ready,
    input  logic                br_taken,
    input  logic [1:0]          br_kind,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic [PC_WIDTH-1:0] br_imm_ext,
    input  logic [PC_WIDTH-1:0] br_reg_target,
    output logic                redirect_flush,
    output logic                misalign_err
);

    pc_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                flush_q, flush_d;
    logic                err_q, err_d;

    logic [PC_WIDTH-1:0] target;
    logic                tgt_misalign;
    logic                kind_illegal;
    logic                take_branch;

    branch_target_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target (
        .kind_i       (br_kind),
        .pc_i         (br_pc),
        .imm_ext_i    (br_imm_ext),
        .reg_target_i (br_reg_target),
        .target_o     (target),
        .misalign_o   (tgt_misalign),
        .illegal_o    (kind_illegal)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        err_d       = err_q;
        fetch_valid = 1'b0;
        br_ready    = 1'b0;
        take_branch = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                fetch_valid = 1'b1;
                br_ready    = 1'b1;
                take_branch = br_valid && br_taken && !kind_illegal;
                if (br_valid && kind_illegal) begin
                    err_d = 1'b1;
                end
                if (take_branch) begin
                    // Redirect wins over any same-cycle fetch handshake.
                    pc_d    = target;
                    flush_d = 1'b1;
                    state_d = REDIR;
                    if (tgt_misalign) begin
                        err_d = 1'b1;
                    end
                end else if (fetch_ready && !stall) begin
                    pc_d = pc_q + PC_WIDTH'(INSTR_BYTES);
                end
            end
            REDIR: state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign fetch_pc       = pc_q;
    assign redirect_flush = flush_q;
    assign misalign_err   = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_fetch_pc_unit;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, fetch_ready, fetch_valid;
    logic [63:0] fetch_pc;
    logic        br_valid, br_ready, br_taken;
    logic [1:0]  br_kind;
    logic [63:0] br_pc, br_imm_ext, br_reg_target;
    logic        redirect_flush, misalign_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: PC value, cycles left before branches/fetches are accepted, flush, error.
    logic [63:0] m_pc;
    int          m_idle;
    logic        m_flush;
    logic        m_err;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_taken       (br_taken),
        .br_kind        (br_kind),
        .br_pc          (br_pc),
        .br_imm_ext     (br_imm_ext),
        .br_reg_target  (br_reg_target),
        .redirect_flush (redirect_flush),
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_idle  = 1;
        m_flush = 1'b0;
        m_err   = 1'b0;
    endtask

    // Applies the rules of one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic taken;
        if (m_idle > 0) begin
            m_idle--;
            m_flush = 1'b0;
        end else begin
            taken = br_valid && br_taken && (br_kind != 2'd3);
            if (br_valid && br_kind == 2'd3) m_err = 1'b1;
            if (taken) begin
                if (br_kind == 2'd2) begin
                    if (br_reg_target % 4 != 0) m_err = 1'b1;
                    m_pc = br_reg_target - (br_reg_target % 4);
                end else begin
                    m_pc = br_pc + br_imm_ext * 64'd4;
                end
                m_flush = 1'b1;
                m_idle  = 1;
            end else begin
                m_flush = 1'b0;
                if (fetch_ready && !stall) m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic check_all();
        chk("fetch_valid", 64'(fetch_valid), 64'(m_idle == 0));
        chk("br_ready", 64'(br_ready), 64'(m_idle == 0));
        chk("fetch_pc", fetch_pc, m_pc);
        chk("redirect_flush", 64'(redirect_flush), 64'(m_flush));
        chk("misalign_err", 64'(misalign_err), 64'(m_err));
    endtask

    task automatic step(input logic st, input logic rdy, input logic bv, input logic bt,
                        input logic [1:0] kd, input logic [63:0] bpc, input logic [63:0] imm,
                        input logic [63:0] rt);
        stall         = st;
        fetch_ready   = rdy;
        br_valid      = bv;
        br_taken      = bt;
        br_kind       = kd;
        br_pc         = bpc;
        br_imm_ext    = imm;
        br_reg_target = rt;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, rdy, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0);
    endtask

    task automatic jump_reg(input logic [63:0] tgt);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 64'h0, 64'h0, tgt);
        idle(1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        stall = 0; fetch_ready = 0; br_valid = 0; br_taken = 0; br_kind = 0;
        br_pc = 0; br_imm_ext = 0; br_reg_target = 0;
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;

        // 1: boot bubble then sequential addresses
        chk("boot_bubble", 64'(fetch_valid), 64'd0);
        idle(1'b1); chk("seq0", fetch_pc, 64'h0); chk("seq0_vld", 64'(fetch_valid), 64'd1);
        idle(1'b1); chk("seq4", fetch_pc, 64'h4);
        idle(1'b1); chk("seq8", fetch_pc, 64'h8);
        idle(1'b1); chk("seq12", fetch_pc, 64'hC);

        // 2: stall holds the PC
        jump_reg(64'h100);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0);
            chk("stall_hold", fetch_pc, 64'h100);
        end
        idle(1'b1); chk("stall_release", fetch_pc, 64'h104);

        // 3: B taken with negative offset
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0);
        chk("b_target", fetch_pc, 64'h1F4);
        chk("b_flush", 64'(redirect_flush), 64'd1);
        chk("b_bubble", 64'(fetch_valid), 64'd0);
        idle(1'b1);
        chk("b_flush_end", 64'(redirect_flush), 64'd0);
        chk("b_after", fetch_pc, 64'h1F4);

        // 4: CB taken beats fetch handshake
        jump_reg(64'h40);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 64'h3C, 64'h5, 64'h0);
        chk("cb_target", fetch_pc, 64'h50);
        idle(1'b1);

        // 5: misaligned BR target, sticky error
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 64'h0, 64'h0, 64'h1003);
        chk("br_target", fetch_pc, 64'h1000);
        chk("br_err", 64'(misalign_err), 64'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("br_err_sticky", 64'(misalign_err), 64'd1);

        // 6: PC wrap, then reset during REDIR
        jump_reg(64'hFFFF_FFFF_FFFF_FFFC);
        idle(1'b1); chk("wrap", fetch_pc, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 64'h0, 64'h10, 64'h0);
        chk("redir_flush", 64'(redirect_flush), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_flush", 64'(redirect_flush), 64'd0);
        chk("rst_pc", fetch_pc, RST_PC);
        chk("rst_err", 64'(misalign_err), 64'd0);
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic, periodically reset to re-arm the sticky error
        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 600; i++) begin
                logic [1:0]  kd;
                logic [63:0] imm, rt, bpc;
                kd  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                bpc = {$urandom, $urandom};
                imm = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom}
                                                  : 64'($signed($urandom_range(0, 64)) - 32);
                rt  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                  : {$urandom, $urandom} & ~64'h3;
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) != 0),
                     kd, bpc, imm, rt);
            end
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
